// File: rtl/alu_disp_pkg.sv
// Shared types and seven-segment constants for the ALU decimal display stage.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit positions of each segment within a 7-bit segment vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction applied to a BCD nibble before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/alu_hex_display_seg7_encode.sv
// BCD digit to active-low seven-segment pattern, with a forced-blank input.
// Codes above 9 cannot occur from the converter and render as blank.
module seg7_encode
  import alu_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/alu_hex_display.sv
// Converts the ALU mux result to three BCD digits by sequential double-dabble
// and drives three active-low seven-segment digits plus the decimal point.
//
// state   | meaning
// IDLE    | display stable; compare input against what is shown
// CONVERT | 8 double-dabble shift steps, cnt counts 0..7
// DONE    | load digit, decimal-point and last_value registers together
module alu_hex_display #(
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       mpy_dp_n,
  input  logic       div_dp_n,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic       dp_n,
  output logic       busy
);

  import alu_disp_pkg::*;

  localparam logic [6:0] LEAD_RST = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_0;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  last_value;
  logic [7:0]  cap_value;
  logic        cap_dp;
  logic [7:0]  shift;
  logic [11:0] bcd;
  logic [2:0]  cnt;

  logic        dp_in;
  logic        change;
  logic        blank2;
  logic        blank1;
  logic [6:0]  seg0;
  logic [6:0]  seg1;
  logic [6:0]  seg2;

  assign dp_in  = mpy_dp_n & div_dp_n;
  // dp_n is the displayed decimal point, so it doubles as the comparison copy.
  assign change = (value != last_value) || (dp_in != dp_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (change) state_nxt = CONVERT;
      CONVERT: if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT) || (state == DONE);
  end

  assign blank2 = (BLANK_LEADING != 0) && (bcd[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd[7:4] == 4'd0);

  seg7_encode u_seg0 (.digit(bcd[3:0]),  .blank(1'b0),   .seg(seg0));
  seg7_encode u_seg1 (.digit(bcd[7:4]),  .blank(blank1), .seg(seg1));
  seg7_encode u_seg2 (.digit(bcd[11:8]), .blank(blank2), .seg(seg2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value <= 8'd0;
      cap_value  <= 8'd0;
      cap_dp     <= 1'b1;
      shift      <= 8'd0;
      bcd        <= 12'd0;
      cnt        <= 3'd0;
      dp_n       <= 1'b1;
      hex0       <= SEG_0;
      hex1       <= LEAD_RST;
      hex2       <= LEAD_RST;
    end else begin
      case (state)
        IDLE: begin
          if (change) begin
            cap_value <= value;
            cap_dp    <= dp_in;
            shift     <= value;
            bcd       <= 12'd0;
            cnt       <= 3'd0;
          end
        end
        CONVERT: begin
          // The 12-bit shift drops the hundreds MSB, which is always 0 for 8-bit input.
          bcd   <= ({dd_adjust(bcd[11:8]), dd_adjust(bcd[7:4]), dd_adjust(bcd[3:0])} << 1)
                   | {11'd0, shift[7]};
          shift <= shift << 1;
          cnt   <= cnt + 3'd1;
        end
        DONE: begin
          hex0       <= seg0;
          hex1       <= seg1;
          hex2       <= seg2;
          dp_n       <= cap_dp;
          last_value <= cap_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hex_display.sv
// Directed bench for alu_hex_display: table of conversions on a blanking and a
// non-blanking instance, plus hand sequences for mid-conversion change and reset.
module tb_alu_hex_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       mpy_dp_n = 1'b1;
  logic       div_dp_n = 1'b1;

  logic [6:0] hex0, hex1, hex2;
  logic       dp_n, busy;
  logic [6:0] hex0_z, hex1_z, hex2_z;
  logic       dp_n_z, busy_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_hex_display u_dut (
    .clk(clk), .rst(rst), .value(value), .mpy_dp_n(mpy_dp_n), .div_dp_n(div_dp_n),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .dp_n(dp_n), .busy(busy)
  );

  alu_hex_display #(.BLANK_LEADING(0)) u_dut_z (
    .clk(clk), .rst(rst), .value(value), .mpy_dp_n(mpy_dp_n), .div_dp_n(div_dp_n),
    .hex0(hex0_z), .hex1(hex1_z), .hex2(hex2_z), .dp_n(dp_n_z), .busy(busy_z)
  );

  typedef struct {
    logic [7:0] value;
    logic       mpy;
    logic       div;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
    logic [6:0] h2z;
    logic [6:0] h1z;
    logic       dp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] h2, input logic [6:0] h1,
                            input logic [6:0] h0, input logic dp);
    check({tag, "_hex2"}, {1'b0, hex2}, {1'b0, h2});
    check({tag, "_hex1"}, {1'b0, hex1}, {1'b0, h1});
    check({tag, "_hex0"}, {1'b0, hex0}, {1'b0, h0});
    check({tag, "_dp_n"}, {7'd0, dp_n}, {7'd0, dp});
  endtask

  initial begin
    vecs[0]  = '{8'd255, 1'b1, 1'b1, 7'h24, 7'h12, 7'h12, 7'h24, 7'h12, 1'b1};
    vecs[1]  = '{8'd7,   1'b1, 1'b1, 7'h7f, 7'h7f, 7'h78, 7'h40, 7'h40, 1'b1};
    vecs[2]  = '{8'd5,   1'b1, 1'b1, 7'h7f, 7'h7f, 7'h12, 7'h40, 7'h40, 1'b1};
    vecs[3]  = '{8'd105, 1'b1, 1'b1, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40, 1'b1};
    vecs[4]  = '{8'd10,  1'b1, 1'b1, 7'h7f, 7'h79, 7'h40, 7'h40, 7'h79, 1'b1};
    vecs[5]  = '{8'd100, 1'b1, 1'b1, 7'h79, 7'h40, 7'h40, 7'h79, 7'h40, 1'b1};
    vecs[6]  = '{8'd0,   1'b1, 1'b1, 7'h7f, 7'h7f, 7'h40, 7'h40, 7'h40, 1'b1};
    vecs[7]  = '{8'd0,   1'b1, 1'b0, 7'h7f, 7'h7f, 7'h40, 7'h40, 7'h40, 1'b0};
    vecs[8]  = '{8'd105, 1'b0, 1'b1, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40, 1'b0};
    vecs[9]  = '{8'd105, 1'b1, 1'b1, 7'h79, 7'h40, 7'h12, 7'h79, 7'h40, 1'b1};
    vecs[10] = '{8'd99,  1'b1, 1'b1, 7'h7f, 7'h10, 7'h10, 7'h40, 7'h10, 1'b1};
    vecs[11] = '{8'd200, 1'b1, 1'b1, 7'h24, 7'h40, 7'h40, 7'h24, 7'h40, 1'b1};

    // Reset state, held and after release with a zero input.
    tick(2);
    check_disp("rst_hold", 7'h7f, 7'h7f, 7'h40, 1'b1);
    check("rst_hold_busy", {7'd0, busy}, 8'd0);
    check("rst_hold_z_hex2", {1'b0, hex2_z}, 8'h40);
    check("rst_hold_z_hex1", {1'b0, hex1_z}, 8'h40);
    rst = 1'b0;
    tick(3);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check_disp("post_rst", 7'h7f, 7'h7f, 7'h40, 1'b1);

    for (int i = 0; i < 12; i++) begin
      value    = vecs[i].value;
      mpy_dp_n = vecs[i].mpy;
      div_dp_n = vecs[i].div;
      tick(1);
      check($sformatf("v%0d_busy_start", i), {7'd0, busy}, 8'd1);
      tick(8);
      check($sformatf("v%0d_busy_done", i), {7'd0, busy}, 8'd1);
      tick(1);
      check($sformatf("v%0d_busy_end", i), {7'd0, busy}, 8'd0);
      check_disp($sformatf("v%0d", i), vecs[i].h2, vecs[i].h1, vecs[i].h0, vecs[i].dp);
      check($sformatf("v%0d_z_hex2", i), {1'b0, hex2_z}, {1'b0, vecs[i].h2z});
      check($sformatf("v%0d_z_hex1", i), {1'b0, hex1_z}, {1'b0, vecs[i].h1z});
      check($sformatf("v%0d_z_hex0", i), {1'b0, hex0_z}, {1'b0, vecs[i].h0});
    end

    // Input change mid-conversion: 42 shows first, then 99 after a fresh conversion.
    value = 8'd42;
    tick(1);
    tick(3);
    value = 8'd99;
    tick(6);
    check("midchg_busy_42", {7'd0, busy}, 8'd0);
    check_disp("midchg_42", 7'h7f, 7'h19, 7'h24, 1'b1);
    tick(1);
    check("midchg_busy_restart", {7'd0, busy}, 8'd1);
    tick(9);
    check("midchg_busy_99", {7'd0, busy}, 8'd0);
    check_disp("midchg_99", 7'h7f, 7'h10, 7'h10, 1'b1);

    // Reset during conversion of 200 discards the partial result.
    value = 8'd200;
    tick(1);
    tick(3);
    check("rstmid_busy_before", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", {7'd0, busy}, 8'd0);
    check_disp("rstmid", 7'h7f, 7'h7f, 7'h40, 1'b1);
    check("rstmid_z_hex2", {1'b0, hex2_z}, 8'h40);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rstmid_restart_busy", {7'd0, busy}, 8'd1);
    tick(9);
    check("rstmid_final_busy", {7'd0, busy}, 8'd0);
    check_disp("rstmid_200", 7'h24, 7'h40, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_hex_display.md
# alu_hex_display

Decimal display stage downstream of the ALU result multiplexer. It takes the mux's 8-bit result and its two active-low decimal-point flags and converts the result to three BCD digits with a sequential double-dabble engine. It drives three active-low seven-segment digits with leading-zero blanking. Digits and decimal point update together, once per completed conversion, so the display never shows a half-converted value.

## Interface
Parameters:
- BLANK_LEADING, default 1: 1 blanks leading zeros in the hundreds and tens digits; 0 always shows all three digits.

Ports:
- clk  in  1  system clock; every register samples on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- value  in  8  unsigned result from the ALU mux.
- mpy_dp_n  in  1  multiply decimal-point flag from the mux; active-low.
- div_dp_n  in  1  divide decimal-point flag from the mux; active-low.
- hex0  out  7  ones digit segments {g,f,e,d,c,b,a}; active-low.
- hex1  out  7  tens digit segments; active-low.
- hex2  out  7  hundreds digit segments; active-low.
- dp_n  out  1  ones-digit decimal point; active-low.
- busy  out  1  high while a conversion is in progress.

## Operation
- Registers:
  - last_value (8b): the value currently displayed.
  - cap_dp (1b): captured decimal point.
  - shift (8b): binary shift register.
  - bcd (12b): three BCD nibbles.
  - cnt (3b): shift-step counter.
  - state.
- FSM states IDLE, CONVERT, DONE.
- IDLE:
  - Condition: value != last_value, or (mpy_dp_n & div_dp_n) != dp_n.
  - Action: shift <= value, bcd <= 0, cnt <= 0, cap_dp <= mpy_dp_n & div_dp_n, state <= CONVERT.
  - Otherwise the FSM holds in IDLE.
- CONVERT, once per clock:
  - Add 3 to each BCD nibble that is ≥5.
  - Then shift {bcd,shift} left one bit.
  - Increment cnt.
  - When cnt==7, go to DONE after this step, for 8 steps in total.
- DONE:
  - Encode the nibbles into hex2/hex1/hex0.
  - dp_n <= cap_dp.
  - last_value <= captured value.
  - state <= IDLE.
- Input changes during CONVERT or DONE are ignored. The next IDLE cycle compares again, so the display always converges to the current input.
- Segment codes for digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank is 1111111.
- Blanking (BLANK_LEADING=1):
  - hex2 is blank when the hundreds digit is 0.
  - hex1 is blank when both hundreds and tens are 0.
  - hex0 is never blank.
  - An internal zero is shown, e.g. 105 displays as "105".
- busy is high exactly in CONVERT and DONE.
- Range: 0–255 always fits in three digits; no overflow path exists.

## Timing
- Reset values (asynchronous assert; values hold until the first post-reset edge):
  - state = IDLE, last_value = 0, cnt = 0, busy = 0.
  - dp_n = 1.
  - hex2 = hex1 = 1111111, hex0 = 1000000 (displays "0").
  - With BLANK_LEADING=0: hex2 = hex1 = 1000000.
- Latency: a change sampled at edge E in IDLE gives outputs valid after edge E+9 (1 capture + 8 shifts, with the display written on the DONE edge).
- Back-to-back: the earliest next capture is edge E+10, so sustained throughput is one update per 10 clocks.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset mid-conversion:
  - All state returns to reset values immediately.
  - The partial result is discarded.
  - A non-zero input restarts conversion on the first edge after reset deasserts.
- Simultaneous change of value and a decimal-point flag in IDLE is captured as a single conversion.

## Structure
- Package alu_disp_pkg holds:
  - the state enum;
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - the segment bit-order definition.
- Sub-module seg7_encode: combinational 4-bit BCD plus blank input in, 7-bit active-low segments out. It is instantiated three times; its outputs are registered in DONE.
- Top module alu_hex_display holds the FSM, the double-dabble datapath and the output registers.

## Test plan
- Reset with value=0 → hex2/hex1 = 1111111, hex0 = 1000000, dp_n = 1, busy = 0. No conversion starts after release.
- value=255 applied in IDLE → busy high for 9 cycles; hex2/hex1/hex0 = 0100100 / 0010010 / 0010010 ("255").
- value=7 → hex2 = hex1 = 1111111, hex0 = 1111000. value=105 → hex2 = 1111001, hex1 = 1000000, hex0 = 0010010.
- value=42, then value changes to 99 at cycle 3 of CONVERT → "42" appears first. A second conversion starts the next IDLE cycle, and "99" appears 10 edges later.
- Assert rst during cycle 4 of converting 200 → outputs return to reset values immediately. After release with value still 200, "200" is displayed 10 edges later.
- div_dp_n=0 with value unchanged → one conversion runs and dp_n goes to 0 with the digits unchanged. With BLANK_LEADING=0 and value=5 → "005".
